// File: rtl/lbp_code_gen.sv
// lbp_code_gen: scans a serial window of eight signed samples and emits the
// 4-bit LBP code of the maximum (or minimum) position, or 4'b0001 when all
// eight samples are equal.
module lbp_code_gen #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              minmax_on,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_LBP,
    output logic [DATA_W-1:0] out_value,
    output logic              out_same
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] best;
    logic [DATA_W-1:0] first;
    logic [2:0]        idx;
    logic              mode;
    logic              all_eq;
    logic [2:0]        cnt;

    logic              accept;
    logic [DATA_W-1:0] upd_best;
    logic [2:0]        upd_idx;
    logic              upd_eq;

    assign in_ready = (state == IDLE) || (state == COLLECT);
    assign accept   = in_valid && in_ready;

    // Running best/index/equality including the current beat (strict compare keeps earliest tie)
    always_comb begin
        upd_best = best;
        upd_idx  = idx;
        upd_eq   = all_eq;
        if (mode ? ($signed(in_data) > $signed(best))
                 : ($signed(in_data) < $signed(best))) begin
            upd_best = in_data;
            upd_idx  = cnt;
        end
        if (in_data != first) begin
            upd_eq = 1'b0;
        end
    end

    // Window collection, result registration and output handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            best      <= '0;
            first     <= '0;
            idx       <= '0;
            mode      <= 1'b0;
            all_eq    <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_LBP   <= '0;
            out_value <= '0;
            out_same  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        best   <= in_data;
                        first  <= in_data;
                        idx    <= '0;
                        mode   <= minmax_on;
                        all_eq <= 1'b1;
                        cnt    <= 3'd1;
                        state  <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        best   <= upd_best;
                        idx    <= upd_idx;
                        all_eq <= upd_eq;
                        // 3-bit count wraps to 0 as the last beat moves us to HOLD
                        cnt    <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            out_valid <= 1'b1;
                            out_same  <= upd_eq;
                            out_LBP   <= upd_eq ? 4'b0001 : {upd_idx, 1'b0};
                            out_value <= upd_eq ? first : upd_best;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_code_gen.sv
// tb_lbp_code_gen: directed literal windows plus randomized traffic checked
// every cycle against a window-level behavioural model.
module tb_lbp_code_gen;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         minmax_on = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [3:0]   out_LBP;
    logic [W-1:0] out_value;
    logic         out_same;

    int n_cmp = 0;
    int n_bad = 0;

    lbp_code_gen #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .minmax_on (minmax_on),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_LBP   (out_LBP),
        .out_value (out_value),
        .out_same  (out_same)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic signed [W-1:0] m_win [8];
    int                  m_n;
    logic                m_mode;
    logic                m_hold;
    logic [3:0]          m_lbp;
    logic [W-1:0]        m_val;
    logic                m_same;

    // Window-level model: gather 8 accepted samples, then derive the code
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = 0; m_mode = 1'b0; m_hold = 1'b0;
            m_lbp = '0; m_val = '0; m_same = 1'b0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
        end else if (in_valid) begin
            logic signed [W-1:0] ext;
            int pos;
            int eqn;
            if (m_n == 0) m_mode = minmax_on;
            m_win[m_n] = $signed(in_data);
            m_n++;
            if (m_n == 8) begin
                ext = m_win[0];
                for (int k = 1; k < 8; k++) begin
                    if (m_mode && m_win[k] > ext) ext = m_win[k];
                    if (!m_mode && m_win[k] < ext) ext = m_win[k];
                end
                pos = -1;
                eqn = 0;
                for (int k = 0; k < 8; k++) begin
                    if (pos < 0 && m_win[k] == ext) pos = k;
                    if (m_win[k] == m_win[0]) eqn++;
                end
                m_same = (eqn == 8);
                m_lbp  = m_same ? 4'b0001 : {pos[2:0], 1'b0};
                m_val  = ext;
                m_hold = 1'b1;
                m_n    = 0;
            end
        end
    end

    logic chk_en = 1'b0;

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_in_ready",  in_ready,  !m_hold);
            check("cyc_out_valid", out_valid, m_hold);
            check("cyc_out_LBP",   out_LBP,   m_lbp);
            check("cyc_out_value", out_value, m_val);
            check("cyc_out_same",  out_same,  m_same);
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [W-1:0] d, input logic m);
        int t;
        in_valid  = 1'b1;
        in_data   = d;
        minmax_on = m;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic window(input logic [8*W-1:0] s, input logic m);
        for (int k = 0; k < 8; k++) send(s[8*W-1-k*W -: W], m);
    endtask

    task automatic expect_result(input string name, input logic [3:0] lbp,
                                 input logic [W-1:0] val, input logic same);
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_lbp"},   out_LBP,   lbp);
        check({name, "_value"}, out_value, val);
        check({name, "_same"},  out_same,  same);
    endtask

    logic [W-1:0] pool [4];
    int           pool_n;

    initial begin
        #12;
        rst = 1'b0;
        #1;
        chk_en = 1'b1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_out_LBP",   out_LBP,   4'b0000);
        check("rst_out_value", out_value, 8'h00);
        check("rst_out_same",  out_same,  1'b0);
        @(posedge clk); #1;

        // Max window: 3,-1,7,2,7,0,-5,1
        window({8'sd3, -8'sd1, 8'sd7, 8'sd2, 8'sd7, 8'sd0, -8'sd5, 8'sd1}, 1'b1);
        expect_result("max_basic", 4'b0100, 8'd7, 1'b0);
        @(posedge clk); #1;
        check("max_basic_valid_1cyc", out_valid, 1'b0);
        check("max_basic_ready_back", in_ready, 1'b1);

        // Min window with tie at 3 and 5
        window({8'sd10, 8'sd4, 8'sd9, -8'sd8, 8'sd6, -8'sd8, 8'sd0, 8'sd5}, 1'b0);
        expect_result("min_tie", 4'b0110, 8'hF8, 1'b0);
        @(posedge clk); #1;

        // All equal
        window({8{8'sd5}}, 1'b1);
        expect_result("all_same", 4'b0001, 8'd5, 1'b1);
        @(posedge clk); #1;

        // Signed comparison, maximum -1 at position 7
        window({-8'sd128, -8'sd100, -8'sd50, -8'sd20, -8'sd10, -8'sd5, -8'sd2, -8'sd1}, 1'b1);
        expect_result("signed_max", 4'b1110, 8'hFF, 1'b0);
        @(posedge clk); #1;

        // Mode toggle after beat 0, 2-cycle gaps, backpressure on the result
        begin
            logic [8*W-1:0] s;
            s = {8'sd1, 8'sd9, 8'sd3, 8'sd4, 8'sd5, -8'sd7, 8'sd2, 8'sd0};
            for (int k = 0; k < 8; k++) begin
                if (k == 7) out_ready = 1'b0;
                send(s[8*W-1-k*W -: W], (k < 3) ? 1'b1 : 1'b0);
                if (k < 7) begin
                    repeat (2) begin @(posedge clk); #1; end
                end
            end
        end
        expect_result("toggle_gap", 4'b0010, 8'd9, 1'b0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom_range(0, 255));
            @(posedge clk); #1;
            expect_result("hold", 4'b0010, 8'd9, 1'b0);
            check("hold_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_valid", out_valid, 1'b0);
        check("release_ready", in_ready, 1'b1);

        // Reset after beat 4 of a window, then a clean window
        window({8'sd100, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0} , 1'b1);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) send(8'd120, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_in_ready",  in_ready,  1'b1);
        check("arst_out_LBP",   out_LBP,   4'b0000);
        check("arst_out_value", out_value, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        window({-8'sd3, -8'sd4, -8'sd2, -8'sd9, -8'sd1, -8'sd6, -8'sd7, -8'sd8}, 1'b1);
        expect_result("after_rst", 4'b1000, 8'hFF, 1'b0);
        @(posedge clk); #1;

        // Randomized traffic: single-value pool, small pool, full range
        for (int ph = 0; ph < 3; ph++) begin
            pool_n = (ph == 0) ? 1 : 3;
            for (int p = 0; p < 4; p++) pool[p] = W'($urandom_range(0, 255));
            for (int c = 0; c < 300; c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = (ph == 2) ? W'($urandom_range(0, 255))
                                      : pool[$urandom_range(0, pool_n - 1)];
                minmax_on = 1'($urandom_range(0, 1));
                out_ready = ($urandom_range(0, 2) != 0);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
